// File: rtl/s2_pkg.sv
// Shared constants and the receiver state encoding for the S2 serial link.
package s2_pkg;

    localparam int NBYTE     = 18;            // bytes per block, data bits per frame
    localparam int DW        = 8;             // byte width, also the number of planes
    localparam int AW        = 5;             // RB2 word address width
    localparam int PAW       = 3;             // plane-address bits at the head of a frame
    localparam int FRAME_LEN = PAW + NBYTE;   // 21 bits per well-formed frame
    localparam int CW        = 5;             // bit counter width

    // Counter values: a complete frame, and the saturation point that marks "too long".
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_LEN + 1);

    // Last drain index, in the drain counter's width.
    localparam logic [AW-1:0] IDX_LAST = AW'(NBYTE - 1);

    // Highest bit column of a buffer byte; plane a lands in column COL_MAX - a.
    localparam logic [PAW-1:0] COL_MAX = PAW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RECV   = 3'd1,
        S_COMMIT = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/s2_serial_receiver_if.sv
// Signal bundle between the S1-side link / RB2 consumer and the S2 receiver.
// Link protocol: sen is active low and frames a burst of sd bits, one bit per
// clock, MSB first; sen returns high for at least one clock between frames.
// There is no back-pressure: every sen=0 sample is consumed. RB2 side: a write
// happens on every cycle with RB2_RW=0, addressed by RB2_A with data RB2_D.
interface s2_serial_receiver_if;
    import s2_pkg::*;

    logic            sen;
    logic            sd;
    logic            RB2_RW;
    logic [AW-1:0]   RB2_A;
    logic [DW-1:0]   RB2_D;
    logic            done;
    logic            err;
    state_e          dbg_state;

    modport master (
        output sen, sd,
        input  RB2_RW, RB2_A, RB2_D, done, err, dbg_state
    );

    modport slave (
        input  sen, sd,
        output RB2_RW, RB2_A, RB2_D, done, err, dbg_state
    );

endinterface

// File: rtl/s2_rx_shift.sv
// Serial frame deserialiser: counts sen=0 samples and shifts sd in MSB first.
// Reports frame completion when sen rises: ok for exactly FRAME_LEN bits,
// err for any other non-empty burst. The frame vector holds its value until
// the next frame's first bit is sampled.
module s2_rx_shift
    import s2_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sen_i,
    input  logic                 sd_i,
    output logic [FRAME_LEN-1:0] frame_o,
    output logic                 frame_ok_o,
    output logic                 frame_err_o
);

    logic [CW-1:0]        cnt_q;
    logic [FRAME_LEN-1:0] shift_q;

    // Shift in frame bits and count them; bits beyond FRAME_LEN are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (!sen_i) begin
            if (cnt_q < CNT_FULL) begin
                shift_q <= {shift_q[FRAME_LEN-2:0], sd_i};
            end
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // End-of-frame classification happens in the cycle sen is seen high.
    always_comb begin
        frame_o     = shift_q;
        frame_ok_o  = sen_i && (cnt_q == CNT_FULL);
        frame_err_o = sen_i && (cnt_q != '0) && (cnt_q != CNT_FULL);
    end

endmodule

// File: rtl/s2_serial_receiver.sv
// S2 receiver top: collects 8 bit-plane frames into an 18x8 buffer, then
// drains the 18 bytes into RB2 on consecutive cycles and pulses done.
module s2_serial_receiver
    import s2_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    s2_serial_receiver_if.slave   bus
);

    state_e               state_q, state_d;
    logic [DW-1:0]        mask_q;
    logic [AW-1:0]        idx_q;
    logic [DW-1:0]        buf_q [NBYTE];
    logic                 ignore_q;
    logic                 err_q;
    logic                 rw_q;
    logic [AW-1:0]        a_q;
    logic [DW-1:0]        d_q;
    logic                 done_q;

    logic [FRAME_LEN-1:0] frame_w;
    logic                 ok_w;
    logic                 ferr_w;
    logic [PAW-1:0]       addr_w;
    logic [NBYTE-1:0]     data_w;
    logic [PAW-1:0]       col_w;
    logic [DW-1:0]        mask_next_w;
    logic                 full_w;
    logic                 drain_busy_w;

    s2_rx_shift u_shift (
        .clk_i       (clk),
        .rst_i       (rst),
        .sen_i       (bus.sen),
        .sd_i        (bus.sd),
        .frame_o     (frame_w),
        .frame_ok_o  (ok_w),
        .frame_err_o (ferr_w)
    );

    // Decode the held frame and see whether committing it completes the block.
    always_comb begin
        addr_w       = frame_w[FRAME_LEN-1 -: PAW];
        data_w       = frame_w[NBYTE-1:0];
        col_w        = COL_MAX - addr_w;
        mask_next_w  = mask_q | (DW'(1) << addr_w);
        full_w       = (mask_next_w == '1);
        // A frame starting in any of these cycles would overlap the write-out.
        drain_busy_w = (state_q == S_DRAIN) || (state_q == S_DONE) ||
                       ((state_q == S_COMMIT) && full_w);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_RECV: begin
                if (ok_w && !ignore_q) begin
                    state_d = S_COMMIT;
                end else if (!bus.sen) begin
                    state_d = S_RECV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: begin
                if (full_w) begin
                    state_d = S_DRAIN;
                end else if (!bus.sen) begin
                    state_d = S_RECV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Plane buffer: a committed frame fills one bit column of all 18 bytes.
    always_ff @(posedge clk) begin
        if (state_q == S_COMMIT) begin
            for (int j = 0; j < NBYTE; j++) begin
                buf_q[j][col_w] <= data_w[j];
            end
        end
    end

    // Mask, drain index, RB2 driver and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            idx_q  <= '0;
            rw_q   <= 1'b1;
            a_q    <= '0;
            d_q    <= '0;
            done_q <= 1'b0;
        end else begin
            rw_q   <= 1'b1;
            done_q <= 1'b0;
            unique case (state_q)
                S_COMMIT: begin
                    mask_q <= mask_next_w;
                    idx_q  <= '0;
                end
                S_DRAIN: begin
                    rw_q  <= 1'b0;
                    a_q   <= idx_q;
                    d_q   <= buf_q[idx_q];
                    idx_q <= idx_q + 1'b1;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    a_q    <= '0;
                    mask_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Protocol errors; frames that begin while draining are discarded whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= 1'b0;
            ignore_q <= 1'b0;
        end else begin
            if (ferr_w) begin
                err_q <= 1'b1;
            end
            if (!bus.sen && drain_busy_w && !ignore_q) begin
                err_q    <= 1'b1;
                ignore_q <= 1'b1;
            end else if (bus.sen) begin
                ignore_q <= 1'b0;
            end
        end
    end

    assign bus.RB2_RW    = rw_q;
    assign bus.RB2_A     = a_q;
    assign bus.RB2_D     = d_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_s2_serial_receiver.sv
// Bench for s2_serial_receiver: table of full 8-plane blocks plus hand-written
// sequences for repeated planes, short/long frames and reset during drain.
module tb_s2_serial_receiver;
  import s2_pkg::*;

  localparam int W = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s2_serial_receiver_if bus();

  s2_serial_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int         checks    = 0;
  int         failures  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [7:0] cur [NBYTE];
  int         done_cnt  = 0;
  int         run_len   = 0;
  logic       prev_done = 1'b0;

  typedef struct {
    logic [NBYTE*DW-1:0] bytes;
    logic [23:0]         order;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every RB2 write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.RB2_RW === 1'b0) begin
      run_len++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %0h with none expected",
                 bus.RB2_A, bus.RB2_D);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rb2_write", {19'd0, bus.RB2_A, bus.RB2_D}, {19'd0, mon_e});
      end
    end else begin
      if (bus.done === 1'b1) chk("write_run_len", run_len, 18);
      run_len = 0;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (prev_done) begin
        checks++;
        failures++;
        $display("FAIL done_width: got done high 2+ cycles expected 1");
      end
    end
    prev_done = bus.done;
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [2:0] a, input logic [17:0] d, input int nbits);
    logic [20:0] f;
    f = {a, d};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.sen = 1'b0;
      bus.sd  = (i < 21) ? f[20-i] : 1'b0;
    end
    @(negedge clk);
    bus.sen = 1'b1;
    bus.sd  = 1'b0;
  endtask

  function automatic logic [17:0] plane_bits(input logic [2:0] a);
    logic [17:0] d;
    for (int j = 0; j < NBYTE; j++) d[j] = cur[j][7 - int'(a)];
    return d;
  endfunction

  task automatic send_plane(input logic [2:0] a);
    send_frame(a, plane_bits(a), 21);
  endtask

  task automatic push_block();
    for (int k = 0; k < NBYTE; k++) exp_q.push_back({AW'(k), cur[k]});
  endtask

  // Count negedges from the final sen rise until done; 21 means done after edge T+20.
  task automatic wait_done(input string name);
    int n;
    n = 999;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
    chk(name, n, 21);
    @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  int ord1 [8] = '{7, 3, 0, 5, 1, 6, 2, 4};
  int dc;

  initial begin
    bus.sen = 1'b1;
    bus.sd  = 1'b0;

    for (int k = 0; k < NBYTE; k++) begin
      vecs[0].bytes[k*8 +: 8] = 8'(k);
      vecs[1].bytes[k*8 +: 8] = (k % 2 == 0) ? 8'hA5 : 8'h5A;
      vecs[2].bytes[k*8 +: 8] = 8'(k * 37 + 11);
    end
    for (int i = 0; i < 8; i++) begin
      vecs[0].order[i*3 +: 3] = 3'(i);
      vecs[1].order[i*3 +: 3] = 3'(ord1[i]);
      vecs[2].order[i*3 +: 3] = 3'((i + 4) % 8);
    end

    // Reset values
    idle(3);
    chk("rst_rw",    bus.RB2_RW, 1);
    chk("rst_a",     bus.RB2_A, 0);
    chk("rst_d",     bus.RB2_D, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_err",   bus.err, 0);
    chk("rst_state", bus.dbg_state, S_IDLE);
    rst = 1'b0;
    idle(2);

    // Table: full blocks in various plane orders
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < NBYTE; k++) cur[k] = vecs[v].bytes[k*8 +: 8];
      dc = done_cnt;
      for (int i = 0; i < 7; i++) send_plane(vecs[v].order[i*3 +: 3]);
      chk($sformatf("vec%0d_no_early_done", v), done_cnt, dc);
      push_block();
      send_plane(vecs[v].order[21 +: 3]);
      wait_done($sformatf("vec%0d_done_latency", v));
      chk($sformatf("vec%0d_done_count", v), done_cnt, dc + 1);
      chk($sformatf("vec%0d_err", v), bus.err, 0);
      chk($sformatf("vec%0d_state", v), bus.dbg_state, S_IDLE);
    end

    // Repeated plane 2: ones then zeros, so bit 5 ends at 0
    for (int k = 0; k < NBYTE; k++) cur[k] = 8'h3C ^ 8'(k * 9);
    dc = done_cnt;
    send_plane(3'd0);
    send_plane(3'd1);
    send_frame(3'd2, 18'h3FFFF, 21);
    send_plane(3'd3);
    send_plane(3'd4);
    send_plane(3'd5);
    send_plane(3'd6);
    send_frame(3'd2, 18'h00000, 21);
    idle(25);
    chk("rep_no_done_7planes", done_cnt, dc);
    for (int k = 0; k < NBYTE; k++) cur[k] = cur[k] & 8'hDF;
    push_block();
    send_plane(3'd7);
    wait_done("rep_done_latency");
    chk("rep_err", bus.err, 0);

    // Short frame then full resend of the same plane
    for (int k = 0; k < NBYTE; k++) cur[k] = 8'(8'hC3 + k * 5);
    send_plane(3'd0);
    send_plane(3'd1);
    send_plane(3'd2);
    send_frame(3'd3, 18'h2AAAA, 10);
    @(negedge clk);
    chk("short_err", bus.err, 1);
    send_plane(3'd3);
    for (int p = 4; p < 7; p++) send_plane(3'(p));
    push_block();
    send_plane(3'd7);
    wait_done("short_done_latency");
    chk("short_err_sticky", bus.err, 1);

    // Reset during drain at write k=6
    for (int k = 0; k < NBYTE; k++) cur[k] = ~8'(k);
    for (int p = 0; p < 7; p++) send_plane(3'(p));
    push_block();
    send_plane(3'd7);
    begin
      int found;
      found = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.RB2_RW === 1'b0 && bus.RB2_A == 5'd6) begin
          found = 1;
          break;
        end
      end
      chk("rstdrain_reached_k6", found, 1);
    end
    dc = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rstdrain_rw", bus.RB2_RW, 1);
    chk("rstdrain_remaining", exp_q.size(), 11);
    exp_q.delete();
    rst = 1'b0;
    idle(25);
    chk("rstdrain_no_done", done_cnt, dc);
    chk("rstdrain_err", bus.err, 0);
    chk("rstdrain_state", bus.dbg_state, S_IDLE);
    for (int k = 0; k < NBYTE; k++) cur[k] = 8'(8'hF0 - k);
    for (int p = 0; p < 7; p++) send_plane(3'(p));
    push_block();
    send_plane(3'd7);
    wait_done("fresh_done_latency");
    chk("fresh_err", bus.err, 0);

    // 22-bit frame for plane 4 is discarded
    for (int k = 0; k < NBYTE; k++) cur[k] = 8'(k * 13) ^ 8'h69;
    dc = done_cnt;
    send_frame(3'd4, plane_bits(3'd4), 22);
    @(negedge clk);
    chk("long_err", bus.err, 1);
    for (int p = 0; p < 8; p++) if (p != 4) send_plane(3'(p));
    idle(40);
    chk("long_no_done", done_cnt, dc);
    chk("long_state", bus.dbg_state, S_IDLE);
    push_block();
    send_plane(3'd4);
    wait_done("long_done_latency");
    chk("long_done_count", done_cnt, dc + 1);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
